// File: rtl/uart.sv
// uart: memory-mapped 8N1 UART for the FemtoRV I/O bus.
// Data register (rw) and status register (r) are selected by sel_dat/sel_cntl.
// Transmitter and receiver run independently, so full duplex works.
// Optional macro UART_BRK_EN enables the Ctrl-C (0x03) brk pulse; without it
// brk is tied low and 0x03 is received as ordinary data.
//
// Receive FSM states:
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized RXD
//   RX_START | half a bit into the start bit; a high re-sample means a glitch
//   RX_DATA  | sampling 8 data bits at mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; 1 accepts the byte, 0 discards it
module uart #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic        wstrb,
  input  logic        sel_dat,
  input  logic        sel_cntl,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        RXD,
  output logic        TXD,
  output logic        brk
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Only the low byte of a write carries data.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------- transmitter ----------------
  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        tx_start;

  assign tx_start = wstrb & sel_dat & ~tx_busy_q;

  // Frame shifter: load {stop, byte, start}, hold each bit DIV clocks.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_start) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, wdata[7:0], 1'b0};
      tx_bit_d   = 4'd9;
      tx_cnt_d   = DIV_M1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == 16'd0) begin
        if (tx_bit_q == 4'd0) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_bit_d   = tx_bit_q - 4'd1;
          tx_cnt_d   = DIV_M1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end
    end
  end

  // Transmit state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= 10'h3FF;
      tx_bit_q   <= 4'd0;
      tx_cnt_q   <= 16'd0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Line idles high whenever no frame is in progress, including right after reset.
  assign TXD = tx_busy_q ? tx_shift_q[0] : 1'b1;

  // ---------------- receiver ----------------
  rx_state_t   rx_state_q, rx_state_d;
  logic        rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_done;
  logic        rx_tick;
  logic        rx_fall;

  assign rx_tick = (rx_cnt_q == 16'd0);
  assign rx_fall = rxd_prev_q & ~rxd_s2_q;

  // Synchronizer (idle-high) and receive state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state logic for the receive FSM.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_tick) rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_tick) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // Receive datapath: bit timer, shifter, and byte acceptance.
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_cnt_d = HALF_M1;
      RX_START: begin
        if (rx_tick) begin
          rx_cnt_d = DIV_M1;
          rx_bit_d = 3'd0;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_cnt_d   = DIV_M1;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_done = rxd_s2_q;
          if (rxd_s2_q) rx_data_d = rx_shift_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_cnt_d = 16'd0;
    endcase
    // A completion in the same cycle as a read-clear leaves the flag set.
    rx_valid_d = rx_valid_q;
    if (rstrb & sel_dat) rx_valid_d = 1'b0;
    if (rx_done)         rx_valid_d = 1'b1;
  end

`ifdef UART_BRK_EN
  logic brk_q, brk_d;

  // Ctrl-C detect, aligned with the cycle rx_valid is set.
  always_comb begin
    brk_d = rx_done && (rx_shift_q == 8'h03);
  end

  // Break pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) brk_q <= 1'b0;
    else        brk_q <= brk_d;
  end

  assign brk = brk_q;
`else
  assign brk = 1'b0;
`endif

  // Register read mux; sel_dat takes priority.
  always_comb begin
    rdata = 32'h0;
    if (sel_dat)       rdata = {22'b0, rx_valid_q, tx_busy_q, rx_data_q};
    else if (sel_cntl) rdata = {22'b0, rx_valid_q, tx_busy_q, 8'h00};
  end

endmodule

// File: tb/tb_uart.sv
// tb_uart: directed, table-driven bench for the uart peripheral (DIV = 104).
module tb_uart;

  logic        clk = 1'b0;
  logic        reset;
  logic        rstrb, wstrb, sel_dat, sel_cntl;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        RXD;
  logic        TXD;
  logic        brk;

  int n_chk  = 0;
  int n_fail = 0;
  int brk_cnt = 0;
  logic [31:0] brk_rdata = 32'h0;

  uart dut (
    .clk(clk), .reset(reset), .rstrb(rstrb), .wstrb(wstrb),
    .sel_dat(sel_dat), .sel_cntl(sel_cntl), .wdata(wdata), .rdata(rdata),
    .RXD(RXD), .TXD(TXD), .brk(brk)
  );

  always #5 clk = ~clk;

  // Count brk cycles and remember the data seen while brk is high.
  always @(negedge clk) begin
    if (brk === 1'b1) begin
      brk_cnt++;
      brk_rdata = rdata;
    end
  end

  typedef struct {
    logic        sd;
    logic        sc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vecs(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      sel_dat  = vecs[i].sd;
      sel_cntl = vecs[i].sc;
      #1;
      check(tag, rdata, vecs[i].exp);
    end
  endtask

  // Send one write and check every cycle of the resulting frame on TXD.
  task automatic tx_frame(input logic [31:0] w, input bit busy_wr);
    logic [9:0] fr;
    fr = {1'b1, w[7:0], 1'b0};
    sel_dat = 1'b1; sel_cntl = 1'b0; wstrb = 1'b1; wdata = w;
    tick(1);
    wstrb = 1'b0; sel_dat = 1'b0; sel_cntl = 1'b1;
    #1;
    for (int k = 0; k <= 1040; k++) begin
      if (k == 0 || k == 500 || k == 1039) check("tx_busy_status", rdata, 32'h100);
      if (k < 1040) check("tx_line_bit", {31'b0, TXD}, {31'b0, fr[k / 104]});
      if (k == 1040) begin
        check("tx_done_status", rdata, 32'h0);
        check("tx_done_line", {31'b0, TXD}, 32'h1);
      end
      if (busy_wr && k == 200) begin
        sel_cntl = 1'b0; sel_dat = 1'b1; wstrb = 1'b1; wdata = 32'h55;
      end
      if (busy_wr && k == 201) begin
        wstrb = 1'b0; sel_dat = 1'b0; sel_cntl = 1'b1;
      end
      if (k < 1040) tick(1);
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = fr[i];
      tick(104);
    end
    RXD = 1'b1;
  endtask

  task automatic clear_rx();
    sel_cntl = 1'b0; sel_dat = 1'b1; rstrb = 1'b1;
    tick(1);
    rstrb = 1'b0;
  endtask

  initial begin
    int b0;
    vecs[0] = '{1'b1, 1'b0, 32'h000};
    vecs[1] = '{1'b0, 1'b1, 32'h000};
    vecs[2] = '{1'b1, 1'b1, 32'h000};
    vecs[3] = '{1'b0, 1'b0, 32'h000};
    vecs[4] = '{1'b1, 1'b0, 32'h2A5};
    vecs[5] = '{1'b0, 1'b1, 32'h200};
    vecs[6] = '{1'b1, 1'b1, 32'h2A5};
    vecs[7] = '{1'b0, 1'b0, 32'h000};

    reset = 1'b0; rstrb = 1'b0; wstrb = 1'b0; sel_dat = 1'b0; sel_cntl = 1'b0;
    wdata = 32'h0; RXD = 1'b1;

    // Reset state, held and after release.
    tick(5);
    check("reset_txd", {31'b0, TXD}, 32'h1);
    check("reset_brk", {31'b0, brk}, 32'h0);
    run_vecs(0, 3, "reset_rdata");
    reset = 1'b1;
    tick(2);
    check("post_reset_txd", {31'b0, TXD}, 32'h1);
    run_vecs(0, 3, "post_reset_rdata");

    // Transmit 0x4321 (low byte 0x21).
    tx_frame(32'h4321, 1'b0);

    // Write while busy is dropped and does not disturb the frame.
    tx_frame(32'h21, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick(50);
      check("no_dropped_frame", {30'b0, TXD, rdata[8]}, 32'h2);
    end

    // Reset mid-transmit forces the line high immediately.
    sel_dat = 1'b1; wstrb = 1'b1; wdata = 32'h00;
    tick(1);
    wstrb = 1'b0; sel_dat = 1'b0; sel_cntl = 1'b1;
    tick(300);
    check("tx_mid_low", {31'b0, TXD}, 32'h0);
    reset = 1'b0;
    #1;
    check("tx_abort_txd", {31'b0, TXD}, 32'h1);
    check("tx_abort_busy", rdata, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Receive 0xA5.
    sel_cntl = 1'b0; sel_dat = 1'b1;
    b0 = brk_cnt;
    rx_send(8'hA5, 1'b1);
    tick(10);
    check("rx_a5", rdata, 32'h2A5);
    check("rx_a5_brk", brk_cnt - b0, 0);
    run_vecs(4, 7, "rx_a5_regmap");
    clear_rx();
    sel_dat = 1'b0; sel_cntl = 1'b1;
    #1;
    check("rx_clear", rdata, 32'h000);

    // Receive 0x03 (Ctrl-C).
    sel_cntl = 1'b0; sel_dat = 1'b1;
    b0 = brk_cnt;
    rx_send(8'h03, 1'b1);
    tick(10);
    check("rx_03", rdata, 32'h203);
`ifdef UART_BRK_EN
    check("brk_pulse_cycles", brk_cnt - b0, 1);
    check("brk_pulse_data", brk_rdata, 32'h203);
`else
    check("brk_pulse_cycles", brk_cnt - b0, 0);
`endif
    clear_rx();

    // Glitch shorter than half a bit is ignored.
    RXD = 1'b0;
    tick(20);
    RXD = 1'b1;
    tick(1100);
    sel_dat = 1'b0; sel_cntl = 1'b1;
    #1;
    check("glitch_status", rdata, 32'h000);
    sel_cntl = 1'b0; sel_dat = 1'b1;
    #1;
    check("glitch_data", rdata, 32'h003);
    rx_send(8'h5A, 1'b1);
    tick(10);
    check("rx_after_glitch", rdata, 32'h25A);
    clear_rx();

    // Framing error: stop bit low discards the byte.
    rx_send(8'h77, 1'b0);
    tick(200);
    check("framing_error", rdata, 32'h05A);

    // Overrun: second byte overwrites, valid stays set.
    rx_send(8'h3C, 1'b1);
    tick(10);
    check("rx_3c", rdata, 32'h23C);
    rx_send(8'h22, 1'b1);
    tick(10);
    check("rx_overrun", rdata, 32'h222);

    // Reset mid-receive discards the partial byte and clears the flag.
    RXD = 1'b0;
    tick(104);
    RXD = 1'b1;
    tick(104);
    RXD = 1'b0;
    tick(300);
    reset = 1'b0;
    RXD = 1'b1;
    #1;
    check("rx_reset_rdata", rdata, 32'h000);
    check("rx_reset_brk", {31'b0, brk}, 32'h0);
    tick(3);
    reset = 1'b1;
    tick(1200);
    check("rx_reset_idle", rdata, 32'h000);
    rx_send(8'hC3, 1'b1);
    tick(10);
    check("rx_after_reset", rdata, 32'h2C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
